// File: rtl/rv_multicycle_core_if.sv
// Request/acknowledge buses between rv_multicycle_core (master) and its
// instruction and data memories (slave). XLEN must match the attached core.
interface rv_multicycle_core_if #(
    parameter int XLEN = 64
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [31:0]     imem_rdata;
    logic            dmem_req;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_addr;
    logic [XLEN-1:0] dmem_wdata;
    logic            dmem_ack;
    logic [XLEN-1:0] dmem_rdata;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/rv_multicycle_core.sv
// Parametrised multicycle RV integer core with handshaked instruction/data memories.
// Define MUL_UNIT_EN to add the iterative shift-add MUL instruction.
module rv_multicycle_core #(
    parameter int              XLEN     = 64,
    parameter int              NREGS    = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                Reset,
    rv_multicycle_core_if.master bus,
    output logic [XLEN-1:0]     pc_out,
    output logic [2:0]          state,
    output logic                halted
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5,
        MUL    = 3'd6
    } coreState_e;

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_ADDI,
        OP_LOAD, OP_STORE, OP_BEQ, OP_BNE, OP_JAL, OP_LUI,
        OP_MUL, OP_ILLEGAL
    } opClass_e;

    localparam int         REG_AW = $clog2(NREGS);
    // Only full-width accesses exist: LD/SD on RV64, LW/SW on RV32.
    localparam logic [2:0] MEM_F3 = (XLEN == 64) ? 3'b011 : 3'b010;

    coreState_e      curState;
    opClass_e        opClass;
    logic [XLEN-1:0] pc, aluOut, mdr, regA, regB;
    logic [31:0]     ir;
    logic            imemReq, dmemReq, dmemWe, haltedQ;
    logic [XLEN-1:0] regFile [NREGS];

    logic [6:0]      opcode, funct7;
    logic [2:0]      funct3;
    logic [4:0]      rd, rs1, rs2;
    logic [XLEN-1:0] immI, immS, immB, immJ, immU;
    logic [XLEN-1:0] rs1Val, rs2Val, aluB, aluResult, pcPlus4, wbValue;
    logic            rdWritable, branchTaken;

    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign funct3 = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign funct7 = ir[31:25];

    assign immI = XLEN'($signed(ir[31:20]));
    assign immS = XLEN'($signed({ir[31:25], ir[11:7]}));
    assign immB = XLEN'($signed({ir[31], ir[7], ir[30:25], ir[11:8], 1'b0}));
    assign immJ = XLEN'($signed({ir[31], ir[19:12], ir[20], ir[30:21], 1'b0}));
    assign immU = XLEN'($signed({ir[31:12], 12'b0}));

    // Register indices beyond the implemented file read as zero and are never written.
    assign rs1Val     = (int'(rs1) < NREGS) ? regFile[rs1[REG_AW-1:0]] : '0;
    assign rs2Val     = (int'(rs2) < NREGS) ? regFile[rs2[REG_AW-1:0]] : '0;
    assign rdWritable = (rd != 5'd0) && (int'(rd) < NREGS);

    assign pcPlus4     = pc + XLEN'(4);
    assign aluB        = (opClass == OP_ADDI) ? immI : regB;
    assign branchTaken = (opClass == OP_BEQ) ? (regA == regB) : (regA != regB);
    assign wbValue     = (opClass == OP_LOAD) ? mdr : aluOut;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        opClass = OP_ILLEGAL;
        case (opcode)
            7'b0110011: begin
                if (funct7 == 7'b0000000) begin
                    case (funct3)
                        3'b000:  opClass = OP_ADD;
                        3'b111:  opClass = OP_AND;
                        3'b110:  opClass = OP_OR;
                        3'b010:  opClass = OP_SLT;
                        default: opClass = OP_ILLEGAL;
                    endcase
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    opClass = OP_SUB;
`ifdef MUL_UNIT_EN
                end else if (funct7 == 7'b0000001 && funct3 == 3'b000) begin
                    opClass = OP_MUL;
`endif
                end
            end
            7'b0010011: if (funct3 == 3'b000) opClass = OP_ADDI;
            7'b0000011: if (funct3 == MEM_F3) opClass = OP_LOAD;
            7'b0100011: if (funct3 == MEM_F3) opClass = OP_STORE;
            7'b1100011: begin
                if (funct3 == 3'b000)      opClass = OP_BEQ;
                else if (funct3 == 3'b001) opClass = OP_BNE;
            end
            7'b1101111: opClass = OP_JAL;
            7'b0110111: opClass = OP_LUI;
            default:    opClass = OP_ILLEGAL;
        endcase
    end

    always_comb begin
        aluResult = '0;
        case (opClass)
            OP_SUB:  aluResult = regA - aluB;
            OP_AND:  aluResult = regA & aluB;
            OP_OR:   aluResult = regA | aluB;
            OP_SLT:  aluResult = XLEN'($signed(regA) < $signed(aluB));
            default: aluResult = regA + aluB;
        endcase
    end

`ifdef MUL_UNIT_EN
    localparam int              MUL_CW   = $clog2(XLEN);
    localparam logic [MUL_CW-1:0] MUL_LAST = MUL_CW'(XLEN - 1);

    logic [XLEN-1:0]   mulMcand, mulMplier, mulAcc, mulAddend;
    logic [MUL_CW-1:0] mulCount;

    assign mulAddend = mulMplier[0] ? mulMcand : '0;
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples
    // the values from before the edge regardless of statement order.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            curState <= FETCH;
            pc       <= RESET_PC;
            ir       <= '0;
            regA     <= '0;
            regB     <= '0;
            aluOut   <= '0;
            mdr      <= '0;
            imemReq  <= 1'b0;
            dmemReq  <= 1'b0;
            dmemWe   <= 1'b0;
            haltedQ  <= 1'b0;
            // NOTE: the register file is flop-based and shares the async reset, so it
            // cannot map to RAM macros; the architectural state must clear on reset.
            for (int i = 0; i < NREGS; i++) regFile[i] <= '0;
`ifdef MUL_UNIT_EN
            mulMcand  <= '0;
            mulMplier <= '0;
            mulAcc    <= '0;
            mulCount  <= '0;
`endif
        end else begin
            case (curState)
                FETCH: begin
                    // The request rises on the first clock after reset, then is raised on
                    // every transition into FETCH so later fetches lose no cycle.
                    if (!imemReq) begin
                        imemReq <= 1'b1;
                    end else if (bus.imem_ack) begin
                        ir       <= bus.imem_rdata;
                        imemReq  <= 1'b0;
                        curState <= DECODE;
                    end
                end
                DECODE: begin
                    regA   <= rs1Val;
                    regB   <= rs2Val;
                    aluOut <= pc + immB;
                    if (opClass == OP_ILLEGAL) begin
                        curState <= HALT;
                        haltedQ  <= 1'b1;
                    end else begin
                        curState <= EXEC;
                    end
                end
                EXEC: begin
                    case (opClass)
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_ADDI: begin
                            aluOut   <= aluResult;
                            curState <= WB;
                        end
                        OP_LOAD, OP_STORE: begin
                            aluOut   <= regA + ((opClass == OP_STORE) ? immS : immI);
                            dmemReq  <= 1'b1;
                            dmemWe   <= (opClass == OP_STORE);
                            curState <= MEM;
                        end
                        OP_BEQ, OP_BNE: begin
                            pc       <= branchTaken ? aluOut : pcPlus4;
                            imemReq  <= 1'b1;
                            curState <= FETCH;
                        end
                        OP_JAL: begin
                            if (rdWritable) regFile[rd[REG_AW-1:0]] <= pcPlus4;
                            pc       <= pc + immJ;
                            imemReq  <= 1'b1;
                            curState <= FETCH;
                        end
                        OP_LUI: begin
                            aluOut   <= immU;
                            curState <= WB;
                        end
`ifdef MUL_UNIT_EN
                        OP_MUL: begin
                            mulMcand  <= regA;
                            mulMplier <= regB;
                            mulAcc    <= '0;
                            mulCount  <= '0;
                            curState  <= MUL;
                        end
`endif
                        default: begin
                            curState <= HALT;
                            haltedQ  <= 1'b1;
                        end
                    endcase
                end
                MEM: begin
                    if (dmemReq && bus.dmem_ack) begin
                        dmemReq <= 1'b0;
                        dmemWe  <= 1'b0;
                        if (opClass == OP_LOAD) begin
                            mdr      <= bus.dmem_rdata;
                            curState <= WB;
                        end else begin
                            pc       <= pcPlus4;
                            imemReq  <= 1'b1;
                            curState <= FETCH;
                        end
                    end
                end
                WB: begin
                    if (rdWritable) regFile[rd[REG_AW-1:0]] <= wbValue;
                    pc       <= pcPlus4;
                    imemReq  <= 1'b1;
                    curState <= FETCH;
                end
`ifdef MUL_UNIT_EN
                MUL: begin
                    mulAcc    <= mulAcc + mulAddend;
                    mulMcand  <= mulMcand << 1;
                    mulMplier <= mulMplier >> 1;
                    mulCount  <= mulCount + 1'b1;
                    if (mulCount == MUL_LAST) begin
                        aluOut   <= mulAcc + mulAddend;
                        curState <= WB;
                    end
                end
`endif
                HALT: curState <= HALT;
                default: begin
                    curState <= HALT;
                    haltedQ  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.imem_req   = imemReq;
    assign bus.imem_addr  = pc;
    assign bus.dmem_req   = dmemReq;
    assign bus.dmem_we    = dmemWe;
    assign bus.dmem_addr  = aluOut;
    assign bus.dmem_wdata = regB;
    assign pc_out         = pc;
    assign state          = curState;
    assign halted         = haltedQ;

endmodule

// File: tb/tb_rv_multicycle_core.sv
// Directed bench for rv_multicycle_core: RV64, 32 registers, reset vector 0x100,
// with behavioural instruction/data memories that insert programmable wait states.
module tb_rv_multicycle_core;

    localparam int XLEN = 64;

    logic clk = 1'b0;
    logic Reset = 1'b0;
    logic [XLEN-1:0] pc_out;
    logic [2:0]      state;
    logic            halted;

    int compared = 0;
    int mismatched = 0;
    int imemWait = 0;
    int dmemWait = 0;

    logic [31:0]     imem [logic [63:0]];
    logic [XLEN-1:0] dmem [logic [63:0]];

    rv_multicycle_core_if #(.XLEN(XLEN)) bus ();

    rv_multicycle_core #(
        .XLEN(XLEN),
        .NREGS(32),
        .RESET_PC(64'h100)
    ) dut (
        .clk(clk),
        .Reset(Reset),
        .bus(bus),
        .pc_out(pc_out),
        .state(state),
        .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic runCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rType(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] iType(input int imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        logic [11:0] v;
        v = imm[11:0];
        return {v, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] sType(input int imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
        logic [11:0] v;
        v = imm[11:0];
        return {v[11:5], rs2, rs1, 3'b011, v[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] bType(input int imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        logic [12:0] v;
        v = imm[12:0];
        return {v[12], v[10:5], rs2, rs1, f3, v[4:1], v[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] jType(input int imm, input logic [4:0] rd);
        logic [20:0] v;
        v = imm[20:0];
        return {v[20], v[10:1], v[11], v[19:12], rd, 7'b1101111};
    endfunction

    // Memory responders: ack after the programmed number of wait cycles, only while requested.
    initial begin
        int iCnt;
        int dCnt;
        iCnt = 0;
        dCnt = 0;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = '0;
        bus.dmem_ack   = 1'b0;
        bus.dmem_rdata = '0;
        forever begin
            @(negedge clk);
            if (bus.imem_req) begin
                bus.imem_rdata = imem.exists(bus.imem_addr) ? imem[bus.imem_addr] : 32'hFFFF_FFFF;
                bus.imem_ack   = (iCnt >= imemWait);
                iCnt++;
            end else begin
                bus.imem_ack = 1'b0;
                iCnt = 0;
            end
            if (bus.dmem_req) begin
                bus.dmem_rdata = dmem.exists(bus.dmem_addr) ? dmem[bus.dmem_addr] : '0;
                bus.dmem_ack   = (dCnt >= dmemWait);
                if (bus.dmem_ack && bus.dmem_we) dmem[bus.dmem_addr] = bus.dmem_wdata;
                dCnt++;
            end else begin
                bus.dmem_ack = 1'b0;
                dCnt = 0;
            end
        end
    end

    initial begin
        imem[64'h100] = iType(5, 5'd0, 3'b000, 5'd1, 7'b0010011);          // ADDI x1,x0,5
        imem[64'h104] = rType(7'b0000000, 5'd1, 5'd1, 3'b000, 5'd2);        // ADD  x2,x1,x1
        imem[64'h108] = sType(8, 5'd2, 5'd0);                               // SD   x2,8(x0)
        imem[64'h10C] = iType(8, 5'd0, 3'b011, 5'd3, 7'b0000011);           // LD   x3,8(x0)
        imem[64'h110] = rType(7'b0100000, 5'd1, 5'd3, 3'b000, 5'd4);        // SUB  x4,x3,x1
        imem[64'h114] = iType(-3, 5'd0, 3'b000, 5'd6, 7'b0010011);          // ADDI x6,x0,-3
        imem[64'h118] = rType(7'b0000000, 5'd1, 5'd6, 3'b010, 5'd7);        // SLT  x7,x6,x1
        imem[64'h11C] = rType(7'b0000000, 5'd6, 5'd1, 3'b010, 5'd8);        // SLT  x8,x1,x6
        imem[64'h120] = rType(7'b0000000, 5'd2, 5'd6, 3'b111, 5'd9);        // AND  x9,x6,x2
        imem[64'h124] = rType(7'b0000000, 5'd2, 5'd1, 3'b110, 5'd10);       // OR   x10,x1,x2
        imem[64'h128] = {20'h80000, 5'd11, 7'b0110111};                     // LUI  x11,0x80000
        imem[64'h12C] = iType(7, 5'd0, 3'b000, 5'd0, 7'b0010011);           // ADDI x0,x0,7
        imem[64'h130] = jType(-272, 5'd12);                                 // JAL  x12,0x20
        imem[64'h020] = bType(16, 5'd1, 5'd1, 3'b000);                      // BEQ  x1,x1,+16
        imem[64'h030] = bType(16, 5'd1, 5'd1, 3'b001);                      // BNE  x1,x1,+16
        imem[64'h034] = iType(7, 5'd0, 3'b000, 5'd14, 7'b0010011);          // ADDI x14,x0,7
        imem[64'h038] = iType(6, 5'd0, 3'b000, 5'd15, 7'b0010011);          // ADDI x15,x0,6
        imem[64'h03C] = rType(7'b0000001, 5'd15, 5'd14, 3'b000, 5'd13);     // MUL  x13,x14,x15
        imem[64'h040] = 32'hFFFF_FFFF;

        runCycles(3);
        check("reset_imem_req", 64'(bus.imem_req), 64'd0);
        check("reset_dmem_req", 64'(bus.dmem_req), 64'd0);
        check("reset_dmem_we", 64'(bus.dmem_we), 64'd0);
        check("reset_halted", 64'(halted), 64'd0);
        check("reset_state", 64'(state), 64'd0);
        check("reset_pc", pc_out, 64'h100);

        @(negedge clk);
        Reset = 1'b1;
        runCycles(1);
        check("first_imem_req", 64'(bus.imem_req), 64'd1);
        check("first_imem_addr", bus.imem_addr, 64'h100);

        runCycles(4);
        check("addi_x1", dut.regFile[1], 64'd5);
        check("addi_pc", pc_out, 64'h104);
        runCycles(4);
        check("add_x2", dut.regFile[2], 64'd10);
        check("add_pc", pc_out, 64'h108);

        dmemWait = 2;
        runCycles(3);
        check("sd_req_c1", 64'(bus.dmem_req), 64'd1);
        check("sd_we", 64'(bus.dmem_we), 64'd1);
        check("sd_addr", bus.dmem_addr, 64'd8);
        check("sd_wdata", bus.dmem_wdata, 64'd10);
        runCycles(1);
        check("sd_req_c2", 64'(bus.dmem_req), 64'd1);
        runCycles(1);
        check("sd_req_c3", 64'(bus.dmem_req), 64'd1);
        check("sd_addr_stable", bus.dmem_addr, 64'd8);
        runCycles(1);
        check("sd_req_drop", 64'(bus.dmem_req), 64'd0);
        check("sd_pc", pc_out, 64'h10C);
        check("sd_mem", dmem.exists(64'd8) ? dmem[64'd8] : 64'hDEAD, 64'd10);

        runCycles(3);
        check("ld_req", 64'(bus.dmem_req), 64'd1);
        check("ld_we", 64'(bus.dmem_we), 64'd0);
        check("ld_addr", bus.dmem_addr, 64'd8);
        runCycles(4);
        check("ld_x3", dut.regFile[3], 64'd10);
        check("ld_pc", pc_out, 64'h110);
        dmemWait = 0;

        runCycles(4);
        check("sub_x4", dut.regFile[4], 64'd5);
        runCycles(4);
        check("addi_neg_x6", dut.regFile[6], 64'hFFFF_FFFF_FFFF_FFFD);
        runCycles(4);
        check("slt_neg_lt_pos", dut.regFile[7], 64'd1);
        runCycles(4);
        check("slt_pos_lt_neg", dut.regFile[8], 64'd0);
        runCycles(4);
        check("and_x9", dut.regFile[9], 64'd8);
        runCycles(4);
        check("or_x10", dut.regFile[10], 64'd15);
        runCycles(4);
        check("lui_sext_x11", dut.regFile[11], 64'hFFFF_FFFF_8000_0000);
        runCycles(4);
        check("x0_write_discard", dut.regFile[0], 64'd0);
        check("x0_pc", pc_out, 64'h130);

        runCycles(3);
        check("jal_pc", pc_out, 64'h20);
        check("jal_link_x12", dut.regFile[12], 64'h134);
        runCycles(3);
        check("beq_taken_pc", pc_out, 64'h30);
        runCycles(3);
        check("bne_not_taken_pc", pc_out, 64'h34);
        runCycles(8);
        check("mul_setup_x15", dut.regFile[15], 64'd6);

`ifdef MUL_UNIT_EN
        runCycles(XLEN + 4);
        check("mul_x13", dut.regFile[13], 64'd42);
        check("mul_pc", pc_out, 64'h40);
        runCycles(2);
`else
        runCycles(2);
        check("mul_illegal_pc", pc_out, 64'h3C);
`endif
        check("halt_state", 64'(state), 64'd5);
        check("halt_flag", 64'(halted), 64'd1);
        runCycles(5);
        check("halt_no_imem_req", 64'(bus.imem_req), 64'd0);
        check("halt_no_dmem_req", 64'(bus.dmem_req), 64'd0);
        check("halt_sticky", 64'(state), 64'd5);

        imem[64'h100] = 32'hFFFF_FFFF;
        Reset = 1'b0;
        #1;
        check("rst2_state", 64'(state), 64'd0);
        check("rst2_halted", 64'(halted), 64'd0);
        check("rst2_pc", pc_out, 64'h100);
        check("rst2_imem_req", 64'(bus.imem_req), 64'd0);
        check("rst2_regs_cleared", dut.regFile[2], 64'd0);
        @(negedge clk);
        Reset = 1'b1;
        runCycles(1);
        check("rst2_first_req", 64'(bus.imem_req), 64'd1);
        check("rst2_first_addr", bus.imem_addr, 64'h100);
        runCycles(2);
        check("illegal_word_halt", 64'(state), 64'd5);
        check("illegal_word_halted", 64'(halted), 64'd1);
        runCycles(3);
        check("illegal_no_imem_req", 64'(bus.imem_req), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
